// File: rtl/register_file_pkg.sv
// Shared constants for the architectural register file: RoB tag sizing,
// register index width and the hard-wired zero register.
package register_file_pkg;
    localparam int ROB_BITS_DEF = 4;
    localparam int ROB_SIZE     = 1 << ROB_BITS_DEF;
    localparam int REG_IDX_W    = 5;
    localparam int DATA_W       = 32;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/register_file.sv
// Architectural register file with rename-status (busy/tag) table, commit
// write-back, issue-time renaming, flush, and commit-forwarding read ports.
module register_file
    import register_file_pkg::*;
#(
    parameter int ROB_BITS = ROB_BITS_DEF,
    parameter int NREG     = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [ROB_BITS-1:0]  issue_rob_id,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic [DATA_W-1:0]    rs1_value,
    output logic                 rs1_busy,
    output logic [ROB_BITS-1:0]  rs1_tag,
    output logic [DATA_W-1:0]    rs2_value,
    output logic                 rs2_busy,
    output logic [ROB_BITS-1:0]  rs2_tag,
    input  logic                 commit_valid,
    input  logic [REG_IDX_W-1:0] commit_rd,
    input  logic [ROB_BITS-1:0]  commit_rob_id,
    input  logic [DATA_W-1:0]    commit_value
);

    // issue_valid and commit_valid are single-cycle strobes with no ready
    // return: each asserted cycle with rdy_in high is consumed on that edge.
    logic [DATA_W-1:0]   regs [NREG];
    logic                busy [NREG];
    logic [ROB_BITS-1:0] tag  [NREG];

    logic commit_en;
    logic issue_en;

    assign commit_en = rdy_in && commit_valid && (commit_rd != REG_ZERO);
    assign issue_en  = rdy_in && issue_valid && (issue_rd != REG_ZERO) && !flush;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                busy[i] <= 1'b0;
                tag[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (commit_en) begin
                regs[commit_rd] <= commit_value;
                if (busy[commit_rd] && (tag[commit_rd] == commit_rob_id))
                    busy[commit_rd] <= 1'b0;
            end
            // Later assignments win: flush overrides everything, issue overrides commit clear.
            if (flush) begin
                for (int i = 0; i < NREG; i++)
                    busy[i] <= 1'b0;
            end else if (issue_en) begin
                busy[issue_rd] <= 1'b1;
                tag[issue_rd]  <= issue_rob_id;
            end
        end
    end

    // Port read: x0 is constant zero, a matching commit bypasses the table,
    // and this cycle's issue rename is deliberately invisible.
    function automatic logic [DATA_W+ROB_BITS:0] read_port(input logic [REG_IDX_W-1:0] rs);
        logic [DATA_W+ROB_BITS:0] r;
        r = '0;
        if (rs == REG_ZERO) begin
            r = '0;
        end else if (commit_valid && (commit_rd == rs) && busy[rs] &&
                     (tag[rs] == commit_rob_id)) begin
            r = {commit_value, 1'b0, {ROB_BITS{1'b0}}};
        end else begin
            r = {regs[rs], busy[rs], tag[rs]};
        end
        return r;
    endfunction

    always_comb begin
        {rs1_value, rs1_busy, rs1_tag} = read_port(rs1);
        {rs2_value, rs2_busy, rs2_tag} = read_port(rs2);
    end

endmodule

// File: tb/tb_register_file.sv
// Directed testbench for register_file: reset, rename/commit, stale commit,
// commit/issue collision, flush, rdy_in hold and x0 behaviour.
module tb_register_file;
    localparam int RB = 4;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in, flush;
    logic          issue_valid, commit_valid;
    logic [4:0]    issue_rd, commit_rd, rs1, rs2;
    logic [RB-1:0] issue_rob_id, commit_rob_id;
    logic [31:0]   commit_value;
    logic [31:0]   rs1_value, rs2_value;
    logic          rs1_busy, rs2_busy;
    logic [RB-1:0] rs1_tag, rs2_tag;

    int n_checks = 0;
    int n_fail   = 0;

    register_file #(.ROB_BITS(RB), .NREG(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
        .rs1(rs1), .rs2(rs2),
        .rs1_value(rs1_value), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
        .rs2_value(rs2_value), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_rob_id(commit_rob_id), .commit_value(commit_value)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_rd = '0; issue_rob_id = '0;
        commit_valid = 1'b0; commit_rd = '0; commit_rob_id = '0; commit_value = '0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; rs1 = '0; rs2 = '0;
        idle();
        step(); step();
        rst_in = 1'b0;
        rs1 = 5'd5; rs2 = 5'd0;
        #1;
        n_checks++;
        if ({rs1_value, rs1_busy, rs1_tag} !== 37'h0) begin
            n_fail++; $display("FAIL reset_rs1: got v=%h b=%b t=%h want 0/0/0", rs1_value, rs1_busy, rs1_tag);
        end
        n_checks++;
        if ({rs2_value, rs2_busy, rs2_tag} !== 37'h0) begin
            n_fail++; $display("FAIL reset_rs2: got v=%h b=%b t=%h want 0/0/0", rs2_value, rs2_busy, rs2_tag);
        end
    endtask

    task automatic test_issue_commit();
        issue_valid = 1'b1; issue_rd = 5'd5; issue_rob_id = 4'd3;
        step(); idle();
        rs1 = 5'd5; #1;
        n_checks++;
        if (rs1_busy !== 1'b1 || rs1_tag !== 4'd3) begin
            n_fail++; $display("FAIL issue_rename: got b=%b t=%h want 1/3", rs1_busy, rs1_tag);
        end
        commit_valid = 1'b1; commit_rd = 5'd5; commit_rob_id = 4'd3; commit_value = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (rs1_value !== 32'hDEADBEEF || rs1_busy !== 1'b0 || rs1_tag !== 4'd0) begin
            n_fail++; $display("FAIL commit_forward: got v=%h b=%b t=%h want deadbeef/0/0", rs1_value, rs1_busy, rs1_tag);
        end
        step(); idle(); #1;
        n_checks++;
        if (rs1_value !== 32'hDEADBEEF || rs1_busy !== 1'b0) begin
            n_fail++; $display("FAIL commit_write: got v=%h b=%b want deadbeef/0", rs1_value, rs1_busy);
        end
    endtask

    task automatic test_stale_commit();
        issue_valid = 1'b1; issue_rd = 5'd7; issue_rob_id = 4'd2;
        step();
        issue_rob_id = 4'd6;
        step(); idle();
        commit_valid = 1'b1; commit_rd = 5'd7; commit_rob_id = 4'd2; commit_value = 32'h11;
        rs1 = 5'd7; #1;
        n_checks++;
        if (rs1_value !== 32'h0 || rs1_busy !== 1'b1 || rs1_tag !== 4'd6) begin
            n_fail++; $display("FAIL stale_no_forward: got v=%h b=%b t=%h want 0/1/6", rs1_value, rs1_busy, rs1_tag);
        end
        step(); idle(); #1;
        n_checks++;
        if (rs1_value !== 32'h11 || rs1_busy !== 1'b1 || rs1_tag !== 4'd6) begin
            n_fail++; $display("FAIL stale_state: got v=%h b=%b t=%h want 11/1/6", rs1_value, rs1_busy, rs1_tag);
        end
    endtask

    task automatic test_collision();
        issue_valid = 1'b1; issue_rd = 5'd9; issue_rob_id = 4'd4;
        step(); idle();
        commit_valid = 1'b1; commit_rd = 5'd9; commit_rob_id = 4'd4; commit_value = 32'h55;
        issue_valid = 1'b1; issue_rd = 5'd9; issue_rob_id = 4'd5;
        rs1 = 5'd9; #1;
        n_checks++;
        if (rs1_value !== 32'h55 || rs1_busy !== 1'b0 || rs1_tag !== 4'd0) begin
            n_fail++; $display("FAIL collision_read: got v=%h b=%b t=%h want 55/0/0", rs1_value, rs1_busy, rs1_tag);
        end
        step(); idle(); #1;
        n_checks++;
        if (rs1_value !== 32'h55 || rs1_busy !== 1'b1 || rs1_tag !== 4'd5) begin
            n_fail++; $display("FAIL collision_state: got v=%h b=%b t=%h want 55/1/5", rs1_value, rs1_busy, rs1_tag);
        end
    endtask

    task automatic test_flush();
        for (int r = 1; r <= 3; r++) begin
            issue_valid = 1'b1; issue_rd = 5'(r); issue_rob_id = 4'(r);
            step();
        end
        idle();
        rs1 = 5'd2; #1;
        n_checks++;
        if (rs1_busy !== 1'b1 || rs1_tag !== 4'd2) begin
            n_fail++; $display("FAIL flush_pre: got b=%b t=%h want 1/2", rs1_busy, rs1_tag);
        end
        flush = 1'b1;
        issue_valid = 1'b1; issue_rd = 5'd4; issue_rob_id = 4'd7;
        commit_valid = 1'b1; commit_rd = 5'd1; commit_rob_id = 4'd1; commit_value = 32'hA1;
        step(); idle();
        rs1 = 5'd1; rs2 = 5'd2; #1;
        n_checks++;
        if (rs1_value !== 32'hA1 || rs1_busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_commit: got v=%h b=%b want a1/0", rs1_value, rs1_busy);
        end
        n_checks++;
        if (rs2_busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_r2: got b=%b want 0", rs2_busy);
        end
        rs1 = 5'd3; rs2 = 5'd4; #1;
        n_checks++;
        if (rs1_busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_r3: got b=%b want 0", rs1_busy);
        end
        n_checks++;
        if (rs2_busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_issue_dropped: got b=%b want 0", rs2_busy);
        end
    endtask

    task automatic test_rdy_low();
        issue_valid = 1'b1; issue_rd = 5'd8; issue_rob_id = 4'd2;
        step(); idle();
        rdy_in = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd8; issue_rob_id = 4'd9;
        commit_valid = 1'b1; commit_rd = 5'd8; commit_rob_id = 4'd2; commit_value = 32'hCAFE;
        flush = 1'b1;
        step(); step();
        idle(); rdy_in = 1'b1;
        rs1 = 5'd8; #1;
        n_checks++;
        if (rs1_value !== 32'h0 || rs1_busy !== 1'b1 || rs1_tag !== 4'd2) begin
            n_fail++; $display("FAIL rdy_hold: got v=%h b=%b t=%h want 0/1/2", rs1_value, rs1_busy, rs1_tag);
        end
    endtask

    task automatic test_x0();
        issue_valid = 1'b1; issue_rd = 5'd0; issue_rob_id = 4'd3;
        commit_valid = 1'b1; commit_rd = 5'd0; commit_rob_id = 4'd0; commit_value = 32'h1234;
        rs1 = 5'd0; #1;
        n_checks++;
        if ({rs1_value, rs1_busy, rs1_tag} !== 37'h0) begin
            n_fail++; $display("FAIL x0_same_cycle: got v=%h b=%b t=%h want 0/0/0", rs1_value, rs1_busy, rs1_tag);
        end
        step(); idle();
        rs2 = 5'd0; #1;
        n_checks++;
        if ({rs2_value, rs2_busy, rs2_tag} !== 37'h0) begin
            n_fail++; $display("FAIL x0_after: got v=%h b=%b t=%h want 0/0/0", rs2_value, rs2_busy, rs2_tag);
        end
    endtask

    task automatic test_reset_priority();
        rdy_in = 1'b0; rst_in = 1'b1;
        step();
        rst_in = 1'b0; rdy_in = 1'b1;
        rs1 = 5'd8; rs2 = 5'd9; #1;
        n_checks++;
        if (rs1_value !== 32'h0 || rs1_busy !== 1'b0 || rs1_tag !== 4'd0) begin
            n_fail++; $display("FAIL reset_over_rdy_r8: got v=%h b=%b t=%h want 0/0/0", rs1_value, rs1_busy, rs1_tag);
        end
        n_checks++;
        if (rs2_value !== 32'h0 || rs2_busy !== 1'b0 || rs2_tag !== 4'd0) begin
            n_fail++; $display("FAIL reset_over_rdy_r9: got v=%h b=%b t=%h want 0/0/0", rs2_value, rs2_busy, rs2_tag);
        end
    endtask

    initial begin
        test_reset();
        test_issue_commit();
        test_stale_commit();
        test_collision();
        test_flush();
        test_rdy_low();
        test_x0();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
